// File: rtl/demo_timer_gen_pkg.sv
// Shared definitions for the demo timer generator: time width, FSM state
// type and a small helper for detecting section boundaries.
package demo_timer_gen_pkg;

  // Width of the demo time value driven into demo_control.
  localparam int DEMO_TIME_BITS = 13;

  // Timer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A section begins on every timer value whose low ten bits are zero.
  function automatic logic is_section(input logic [DEMO_TIME_BITS-1:0] t);
    return (t[9:0] == 10'd0);
  endfunction

endpackage

// File: rtl/demo_timer_gen.sv
// Demo timer generator: divides frame_tick by FRAMES_PER_TICK and advances a
// demo time counter, with pause/step/seek control and wrap-or-stop at the end.
module demo_timer_gen
  import demo_timer_gen_pkg::*;
#(
  parameter int FRAMES_PER_TICK = 3,
  parameter int LOOP            = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic                      step,
  input  logic                      seek_valid,
  input  logic [DEMO_TIME_BITS-1:0] seek_time,
  output logic                      seek_ready,
  output logic [DEMO_TIME_BITS-1:0] timer,
  output logic                      tick,
  output logic                      section_start,
  output logic                      done
);

  localparam logic [7:0]                PRESC_LAST = 8'(FRAMES_PER_TICK - 1);
  localparam logic [DEMO_TIME_BITS-1:0] TIMER_MAX  = '1;
  localparam logic                      STOP_AT_END = (LOOP == 0);

  state_t                    state;
  logic [7:0]                presc;

  logic                      seek_accept;
  logic                      presc_wrap;
  logic                      step_adv;
  logic                      advance;
  logic                      hit_end;
  logic [DEMO_TIME_BITS-1:0] timer_inc;

  // Seeks are only taken when the timer is not free-running.
  assign seek_ready  = (state != ST_RUN);
  assign done        = (state == ST_DONE);
  assign seek_accept = seek_valid && seek_ready;

  // Advance sources: prescaler rollover while running, or a step while paused.
  // A seek in the same cycle always wins over a step.
  assign presc_wrap = (state == ST_RUN) && frame_tick && (presc == PRESC_LAST);
  assign step_adv   = (state == ST_PAUSE) && step;
  assign advance    = !seek_accept && (presc_wrap || step_adv);
  assign timer_inc  = timer + 1'b1;

  // An advance from the last value with looping disabled parks the timer.
  assign hit_end = advance && (timer == TIMER_MAX) && STOP_AT_END;

  // FSM, prescaler, timer and pulse outputs share one registered process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      presc         <= 8'd0;
      timer         <= '0;
      tick          <= 1'b0;
      section_start <= 1'b0;
    end else begin
      tick          <= 1'b0;
      section_start <= 1'b0;

      if (seek_accept) begin
        timer         <= seek_time;
        presc         <= 8'd0;
        state         <= ST_PAUSE;
        section_start <= is_section(seek_time);
      end else begin
        if ((state == ST_RUN) && frame_tick) begin
          presc <= presc_wrap ? 8'd0 : presc + 8'd1;
        end

        if (advance && !hit_end) begin
          timer         <= timer_inc;
          tick          <= 1'b1;
          section_start <= is_section(timer_inc);
        end

        unique case (state)
          ST_IDLE: begin
            if (run) state <= ST_RUN;
          end
          ST_RUN: begin
            if (hit_end)   state <= ST_DONE;
            else if (!run) state <= ST_PAUSE;
          end
          ST_PAUSE: begin
            // A step holds the state this cycle; run resumes afterwards.
            if (step_adv) begin
              if (hit_end) state <= ST_DONE;
            end else if (run) begin
              state <= ST_RUN;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demo_timer_gen.sv
// Directed bench for demo_timer_gen: one looping and one stopping instance
// share the same stimulus and are compared against hand-computed values.
module tb_demo_timer_gen;
  import demo_timer_gen_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      frame_tick;
  logic                      run;
  logic                      step;
  logic                      seek_valid;
  logic [DEMO_TIME_BITS-1:0] seek_time;

  logic                      l_seek_ready, s_seek_ready;
  logic [DEMO_TIME_BITS-1:0] l_timer, s_timer;
  logic                      l_tick, s_tick;
  logic                      l_sec, s_sec;
  logic                      l_done, s_done;

  int checks   = 0;
  int failures = 0;
  int tick_count;

  always #5 clk = ~clk;

  demo_timer_gen #(.FRAMES_PER_TICK(3), .LOOP(1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .seek_valid(seek_valid), .seek_time(seek_time), .seek_ready(l_seek_ready),
    .timer(l_timer), .tick(l_tick), .section_start(l_sec), .done(l_done)
  );

  demo_timer_gen #(.FRAMES_PER_TICK(3), .LOOP(0)) dut_stop (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .seek_valid(seek_valid), .seek_time(seek_time), .seek_ready(s_seek_ready),
    .timer(s_timer), .tick(s_tick), .section_start(s_sec), .done(s_done)
  );

  // Count one comparison and report it if observed differs from expected.
  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot for one instance.
  task automatic check_loop(input string tag, input logic [31:0] t, input logic tk,
                            input logic sec, input logic dn, input logic rdy);
    check_val({tag, "_l_timer"}, 32'(l_timer), t);
    check_val({tag, "_l_tick"},  32'(l_tick),  32'(tk));
    check_val({tag, "_l_sec"},   32'(l_sec),   32'(sec));
    check_val({tag, "_l_done"},  32'(l_done),  32'(dn));
    check_val({tag, "_l_ready"}, 32'(l_seek_ready), 32'(rdy));
  endtask

  task automatic check_stop(input string tag, input logic [31:0] t, input logic tk,
                            input logic sec, input logic dn, input logic rdy);
    check_val({tag, "_s_timer"}, 32'(s_timer), t);
    check_val({tag, "_s_tick"},  32'(s_tick),  32'(tk));
    check_val({tag, "_s_sec"},   32'(s_sec),   32'(sec));
    check_val({tag, "_s_done"},  32'(s_done),  32'(dn));
    check_val({tag, "_s_ready"}, 32'(s_seek_ready), 32'(rdy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; step = 1'b0;
    seek_valid = 1'b0; seek_time = '0;

    // Reset state
    repeat (3) tick_clk();
    $display("txn reset");
    check_loop("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_stop("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick_clk();
    check_val("idle_ready", 32'(l_seek_ready), 32'h1);

    // Run: 9 frame ticks give 3 advances
    run = 1'b1;
    tick_clk();
    check_val("run_ready", 32'(l_seek_ready), 32'h0);
    tick_count = 0;
    for (int i = 0; i < 9; i++) begin
      frame_tick = 1'b1;
      tick_clk();
      frame_tick = 1'b0;
      check_val("run_tick", 32'(l_tick), 32'((i % 3) == 2));
      check_val("run_timer", 32'(l_timer), 32'((i + 1) / 3));
      if (l_tick) tick_count++;
      tick_clk();
      check_val("run_tick_off", 32'(l_tick), 32'h0);
    end
    $display("txn run9 timer=0x%0h ticks=%0d", l_timer, tick_count);
    check_val("run_tick_count", 32'(tick_count), 32'h3);
    check_val("run_s_timer", 32'(s_timer), 32'h3);

    // One extra frame tick leaves presc at 1, then pause
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    check_val("presc1_timer", 32'(l_timer), 32'h3);
    run = 1'b0;
    tick_clk();
    check_val("pause_ready", 32'(l_seek_ready), 32'h1);

    // Seek 0x3FF then step across a section boundary
    seek_valid = 1'b1; seek_time = 13'h03FF;
    tick_clk();
    seek_valid = 1'b0;
    $display("txn seek 0x3ff");
    check_loop("seek3ff", 32'h3FF, 1'b0, 1'b0, 1'b0, 1'b1);
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    $display("txn step");
    check_loop("step", 32'h400, 1'b1, 1'b1, 1'b0, 1'b1);
    check_stop("step", 32'h400, 1'b1, 1'b1, 1'b0, 1'b1);
    tick_clk();
    check_loop("step_after", 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);

    // Resume: seek cleared presc, so three frame ticks are needed
    run = 1'b1;
    tick_clk();
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      tick_clk();
      frame_tick = 1'b0;
      check_val("resume_tick", 32'(l_tick), 32'(k == 2));
      check_val("resume_timer", 32'(l_timer), (k == 2) ? 32'h401 : 32'h400);
      tick_clk();
    end

    // Seek while running is ignored; accepted once paused, step ignored
    seek_valid = 1'b1; seek_time = 13'h0800;
    tick_clk();
    $display("txn seek in run");
    check_val("runseek_timer", 32'(l_timer), 32'h401);
    check_val("runseek_ready", 32'(l_seek_ready), 32'h0);
    run = 1'b0;
    tick_clk();
    check_val("toPause_timer", 32'(l_timer), 32'h401);
    check_val("toPause_ready", 32'(l_seek_ready), 32'h1);
    step = 1'b1;
    tick_clk();
    step = 1'b0; seek_valid = 1'b0;
    $display("txn seek 0x800 with step");
    check_loop("seek800", 32'h800, 1'b0, 1'b1, 1'b0, 1'b1);
    tick_clk();
    check_val("seek800_sec_off", 32'(l_sec), 32'h0);

    // End of range: loop wraps, stop parks in DONE
    seek_valid = 1'b1; seek_time = 13'h1FFF;
    tick_clk();
    seek_valid = 1'b0;
    check_loop("seekmax", 32'h1FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_stop("seekmax", 32'h1FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run = 1'b1;
    tick_clk();
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      tick_clk();
      frame_tick = 1'b0;
      if (k < 2) begin
        check_val("endpre_s_timer", 32'(s_timer), 32'h1FFF);
        check_val("endpre_s_done", 32'(s_done), 32'h0);
      end else begin
        $display("txn end of range");
        check_stop("end", 32'h1FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        check_loop("end", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      tick_clk();
    end
    check_val("end_l_sec_off", 32'(l_sec), 32'h0);

    // DONE ignores step and run; RUN ignores step
    step = 1'b1; frame_tick = 1'b1;
    tick_clk();
    step = 1'b0; frame_tick = 1'b0;
    check_stop("doneign", 32'h1FFF, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("runstep_l_timer", 32'(l_timer), 32'h0);
    check_val("runstep_l_tick", 32'(l_tick), 32'h0);

    // Seek 0 leaves DONE with a section pulse
    seek_valid = 1'b1; seek_time = 13'h0000; run = 1'b0;
    tick_clk();
    seek_valid = 1'b0;
    $display("txn seek 0 from done");
    check_stop("seek0", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_loop("seek0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset with an increment pending
    seek_valid = 1'b1; seek_time = 13'h0123;
    tick_clk();
    seek_valid = 1'b0;
    check_val("seek123", 32'(l_timer), 32'h123);
    run = 1'b1;
    tick_clk();
    frame_tick = 1'b1;
    tick_clk();
    tick_clk();
    check_val("prereset_timer", 32'(l_timer), 32'h123);
    #2 rst_n = 1'b0;
    #1;
    $display("txn async reset");
    check_loop("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_stop("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_clk();
    frame_tick = 1'b0; run = 1'b0; rst_n = 1'b1;
    check_val("released_timer", 32'(l_timer), 32'h0);
    tick_clk();
    check_loop("idle_after", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run = 1'b1;
    tick_clk();
    check_val("idle_to_run", 32'(l_seek_ready), 32'h0);
    check_val("idle_to_run_timer", 32'(l_timer), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demo_timer_gen.md
DEMO_TIMER_GEN -- requirements
Module: demo_timer_gen

Interface
REQ-001 Parameter FRAMES_PER_TICK, default 3: number of frame_tick pulses per timer increment; legal range 1..255.
REQ-002 Parameter LOOP, default 1: 1 = wrap to 0 after the last timer value; 0 = stop at the last value.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 frame_tick  input  1  one-cycle pulse once per video frame.
REQ-006 run  input  1  level; 1 = advance, 0 = pause.
REQ-007 step  input  1  one-cycle pulse; advances the timer by one while paused.
REQ-008 seek_valid  input  1  seek request.
REQ-009 seek_time  input  DEMO_TIME_BITS  seek target value.
REQ-010 seek_ready  output  1  seek accept qualifier.
REQ-011 timer  output  DEMO_TIME_BITS  demo time; drives the demo_control timer input.
REQ-012 tick  output  1  one-cycle pulse on the cycle after each increment.
REQ-013 section_start  output  1  one-cycle pulse when the timer takes a new value whose bits [9:0] are 0.
REQ-014 done  output  1  high while in DONE.

Function
REQ-015 FSM states: IDLE, RUN, PAUSE, DONE; the state is encoded in a registered enum.
REQ-016 IDLE->RUN when run=1; RUN->PAUSE when run=0; PAUSE->RUN when run=1 and no seek is accepted that cycle.
REQ-017 Prescaler: an 8-bit counter presc counts frame_tick pulses in RUN only; presc holds in all other states.
REQ-018 In RUN with frame_tick=1: if presc==FRAMES_PER_TICK-1, then presc<=0 and an advance occurs; otherwise presc increments.
REQ-019 Advance: timer<=timer+1, with a registered result and a registered tick pulse (1-cycle latency from the qualifying frame_tick edge to timer/tick).
REQ-020 Advance from the all-ones timer value, LOOP=1: timer<=0, state stays RUN, and section_start pulses.
REQ-021 Advance from the all-ones timer value, LOOP=0: timer holds all-ones, no tick, and the state goes to DONE.
REQ-022 step in PAUSE: one advance regardless of presc; presc is unchanged; the same all-ones rules apply.
REQ-023 step is ignored in IDLE, RUN and DONE.
REQ-024 seek_ready=1 in IDLE, PAUSE and DONE; seek_ready=0 in RUN.
REQ-025 Seek accepted (seek_valid && seek_ready): timer<=seek_time, presc<=0, and the state becomes PAUSE (from IDLE, PAUSE or DONE); no tick pulse.
REQ-026 Priority within one cycle: seek accept > step > run-driven transition.
REQ-027 A seek to a value whose bits [9:0] are 0 pulses section_start (the timer takes a new value).
REQ-028 DONE is left only by seek; run and step are ignored in DONE.
REQ-029 seek_valid with seek_ready=0 has no effect and need not be held by the initiator.
REQ-030 section_start and tick are never asserted two consecutive cycles by a single event.

Reset
REQ-031 rst_n=0 asynchronously forces state=IDLE, timer=0, presc=0, tick=0, section_start=0, done=0; seek_ready follows the state (1).
REQ-032 Reset mid-advance discards the pending increment; the first cycle after release shows timer=0.

Structure
REQ-033 DEMO_TIME_BITS and the state enum type belong in the shared common header/package; FRAMES_PER_TICK and LOOP stay as module parameters.
REQ-034 The block is a single module with no sub-module; the prescaler and FSM are inline.

Verification (DEMO_TIME_BITS=13, FRAMES_PER_TICK=3)
REQ-035 Reset, run=1, 9 frame_tick pulses -> timer=3 with exactly 3 tick pulses, each one cycle after every 3rd frame_tick.
REQ-036 Pause: seek 0x03FF, step -> timer=0x0400, section_start=1 for one cycle, tick=1, presc unchanged.
REQ-037 LOOP=0: seek 0x1FFF, run=1, 3 frame_ticks -> timer stays 0x1FFF, done=1, seek_ready=1; seek 0 then gives PAUSE, done=0, section_start pulse.
REQ-038 LOOP=1: same stimulus as REQ-037 -> timer=0, section_start pulse, state RUN, done=0.
REQ-039 In RUN: seek_valid=1 with seek_time=0x0800 -> ignored; then run=0, and on the next cycle the seek is accepted with timer=0x0800; step in the same cycle as the seek is ignored.
REQ-040 rst_n low for 1 cycle mid-run at timer=0x0123 -> all outputs at reset values immediately, IDLE after release.
